router_psum_wb: RTL and testbench
=================================

ROUTER_PSUM_WB -- requirements
Module: router_psum_wb

Interface
- REQ-001: Parameter DATA_BITWIDTH, default 16, width of psum data words.
- REQ-002: Parameter ADDR_BITWIDTH_GLB, default 10, width of GLB addresses.
- REQ-003: Parameter ADDR_BITWIDTH_SPAD, default 9, width of spad addresses.
- REQ-004: Parameter OUT_SIZE, default 3; transaction length N = OUT_SIZE**2 psums.
- REQ-005: Parameter PSUM_SPAD_ADDR, default 0, spad base address of the psum block.
- REQ-006: Parameter PSUM_GLB_ADDR, default 500, GLB base address for writeback.
- REQ-007: clk  input  1  clock; all logic on posedge.
- REQ-008: reset  input  1  synchronous, active-high.
- REQ-009: write_psum_ctrl  input  1  start request from control unit.
- REQ-010: accumulate  input  1  1 = GLB read-modify-write (add), 0 = overwrite.
- REQ-011: r_data_spad_psum  input  DATA_BITWIDTH  spad read data, valid the cycle after read_req_spad_psum.
- REQ-012: r_addr_spad_psum  output  ADDR_BITWIDTH_SPAD  spad read address.
- REQ-013: read_req_spad_psum  output  1  spad read strobe.
- REQ-014: r_data_glb_psum  input  DATA_BITWIDTH  GLB read data, valid the cycle after read_req_glb_psum.
- REQ-015: r_addr_glb_psum  output  ADDR_BITWIDTH_GLB  GLB read address.
- REQ-016: read_req_glb_psum  output  1  GLB read strobe.
- REQ-017: w_data_glb_psum / w_addr_glb_psum  output  DATA_BITWIDTH / ADDR_BITWIDTH_GLB  GLB write data/address.
- REQ-018: write_en_glb_psum  output  1  GLB write strobe, one cycle per element.
- REQ-019: busy  output  1  high in every non-IDLE state.
- REQ-020: psum_done  output  1  single-cycle completion pulse.

Function
- REQ-021: FSM states IDLE, RD_SPAD, CAP_SPAD, RD_GLB, CAP_GLB, WR_GLB, DONE; strobes and busy are decoded from the state register (Moore).
- REQ-022: IDLE: on write_psum_ctrl=1, latch accumulate into acc_mode, clear element counter i, go RD_SPAD; else stay.
- REQ-023: RD_SPAD: read_req_spad_psum=1, r_addr_spad_psum=PSUM_SPAD_ADDR+i; next CAP_SPAD.
- REQ-024: CAP_SPAD: register r_data_spad_psum into psum_reg; next RD_GLB if acc_mode else WR_GLB.
- REQ-025: RD_GLB: read_req_glb_psum=1, r_addr_glb_psum=PSUM_GLB_ADDR+i; next CAP_GLB.
- REQ-026: CAP_GLB: psum_reg <= psum_reg + r_data_glb_psum, truncated modulo 2**DATA_BITWIDTH (no saturation); next WR_GLB.
- REQ-027: WR_GLB: write_en_glb_psum=1, w_addr_glb_psum=PSUM_GLB_ADDR+i, w_data_glb_psum=psum_reg; if i==N-1 go DONE, else i<=i+1 and go RD_SPAD.
- REQ-028: DONE: psum_done=1 for exactly one cycle; next IDLE.
- REQ-029: Start sampled in cycle 0: element i written in cycle 3i+3 (overwrite) or 5i+5 (accumulate); psum_done in cycle 3N+1 or 5N+1.
- REQ-030: write_psum_ctrl and accumulate are ignored while busy=1; accumulate changes mid-transaction have no effect.
- REQ-031: write_psum_ctrl held high through DONE starts the next transaction on the cycle after DONE (from IDLE).
- REQ-032: Address arithmetic wraps modulo 2**width of the respective address bus.
- REQ-033: Counter i is sized to hold N-1; each element is written exactly once, in ascending address order.

Reset
- REQ-034: reset=1 forces state IDLE, i=0, acc_mode=0, psum_reg=0, every output 0, on the next edge, regardless of state.
- REQ-035: Reset mid-transaction produces no further write_en_glb_psum or psum_done; the aborted transaction is not resumed.

Verification
- REQ-036: OUT_SIZE=3, spad[0..8]=1..9, accumulate=0, start pulse -> GLB writes addr 500..508 with data 1..9 in cycles 3,6,...,27; psum_done in cycle 28 only.
- REQ-037: Same spad data, GLB[500..508]=100, accumulate=1 -> writes 101..109 in cycles 5,10,...,45; one GLB read per element before each write; psum_done in cycle 46.
- REQ-038: Accumulate with spad[0]=0xFFFF, GLB[500]=0x0002 -> GLB[500] written 0x0001.
- REQ-039: Start pulse and accumulate toggle while busy -> no restart, mode unchanged, exactly 9 writes, one psum_done.
- REQ-040: reset asserted in the cycle after the 4th write -> all outputs 0 next cycle, no further writes, no psum_done; a new start then runs a full 9-element transaction from addr 500.
- REQ-041: write_psum_ctrl held high continuously -> back-to-back transactions, each with 9 writes and one psum_done, separated by one IDLE cycle.

Source files
------------

// File: rtl/router_psum_wb_if.sv
// rtl/router_psum_wb_if.sv - control, spad read, GLB read/write and status signals of the psum writeback router
`timescale 1ns/1ps
interface router_psum_wb_if #(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_GLB  = 10,
    parameter int ADDR_BITWIDTH_SPAD = 9
);
    logic                          write_psum_ctrl;
    logic                          accumulate;
    logic [DATA_BITWIDTH-1:0]      r_data_spad_psum;
    logic [ADDR_BITWIDTH_SPAD-1:0] r_addr_spad_psum;
    logic                          read_req_spad_psum;
    logic [DATA_BITWIDTH-1:0]      r_data_glb_psum;
    logic [ADDR_BITWIDTH_GLB-1:0]  r_addr_glb_psum;
    logic                          read_req_glb_psum;
    logic [DATA_BITWIDTH-1:0]      w_data_glb_psum;
    logic [ADDR_BITWIDTH_GLB-1:0]  w_addr_glb_psum;
    logic                          write_en_glb_psum;
    logic                          busy;
    logic                          psum_done;

    // router side: issues memory requests and reports status
    modport master (
        input  write_psum_ctrl, accumulate, r_data_spad_psum, r_data_glb_psum,
        output r_addr_spad_psum, read_req_spad_psum, r_addr_glb_psum, read_req_glb_psum,
               w_data_glb_psum, w_addr_glb_psum, write_en_glb_psum, busy, psum_done
    );

    // control unit and memories
    modport slave (
        output write_psum_ctrl, accumulate, r_data_spad_psum, r_data_glb_psum,
        input  r_addr_spad_psum, read_req_spad_psum, r_addr_glb_psum, read_req_glb_psum,
               w_data_glb_psum, w_addr_glb_psum, write_en_glb_psum, busy, psum_done
    );
endinterface

// File: rtl/router_psum_wb.sv
// rtl/router_psum_wb.sv - moves an OUT_SIZE**2 psum block from spad to GLB, optionally accumulating
`timescale 1ns/1ps
module router_psum_wb #(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_GLB  = 10,
    parameter int ADDR_BITWIDTH_SPAD = 9,
    parameter int OUT_SIZE           = 3,
    parameter int PSUM_SPAD_ADDR     = 0,
    parameter int PSUM_GLB_ADDR      = 500
) (
    input  logic            clk,
    input  logic            reset,
    router_psum_wb_if.master bus
);
    localparam int N     = OUT_SIZE * OUT_SIZE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE, RD_SPAD, CAP_SPAD, RD_GLB, CAP_GLB, WR_GLB, DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [CNT_W-1:0]         idx;
    logic                     acc_mode;
    logic [DATA_BITWIDTH-1:0] psum_reg;

    // Base plus element index, wrapping at the width of each address bus.
    logic [ADDR_BITWIDTH_SPAD-1:0] spad_addr;
    logic [ADDR_BITWIDTH_GLB-1:0]  glb_addr;
    assign spad_addr = ADDR_BITWIDTH_SPAD'(PSUM_SPAD_ADDR) + ADDR_BITWIDTH_SPAD'(idx);
    assign glb_addr  = ADDR_BITWIDTH_GLB'(PSUM_GLB_ADDR) + ADDR_BITWIDTH_GLB'(idx);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (bus.write_psum_ctrl) state_next = RD_SPAD;
            RD_SPAD:  state_next = CAP_SPAD;
            CAP_SPAD: state_next = acc_mode ? RD_GLB : WR_GLB;
            RD_GLB:   state_next = CAP_GLB;
            CAP_GLB:  state_next = WR_GLB;
            WR_GLB:   state_next = (idx == LAST_IDX) ? DONE : RD_SPAD;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath: mode latch, element counter and the psum being written back.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            acc_mode <= 1'b0;
            psum_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.write_psum_ctrl) begin
                        acc_mode <= bus.accumulate;
                        idx      <= '0;
                    end
                end
                CAP_SPAD: psum_reg <= bus.r_data_spad_psum;
                CAP_GLB:  psum_reg <= psum_reg + bus.r_data_glb_psum;
                WR_GLB:   if (idx != LAST_IDX) idx <= idx + 1'b1;
                default:  ;
            endcase
        end
    end

    // Moore outputs; address and data buses are held at zero outside their strobe state.
    always_comb begin
        bus.r_addr_spad_psum   = '0;
        bus.read_req_spad_psum = 1'b0;
        bus.r_addr_glb_psum    = '0;
        bus.read_req_glb_psum  = 1'b0;
        bus.w_data_glb_psum    = '0;
        bus.w_addr_glb_psum    = '0;
        bus.write_en_glb_psum  = 1'b0;
        bus.busy               = (state != IDLE);
        bus.psum_done          = 1'b0;
        case (state)
            RD_SPAD: begin
                bus.read_req_spad_psum = 1'b1;
                bus.r_addr_spad_psum   = spad_addr;
            end
            RD_GLB: begin
                bus.read_req_glb_psum = 1'b1;
                bus.r_addr_glb_psum   = glb_addr;
            end
            WR_GLB: begin
                bus.write_en_glb_psum = 1'b1;
                bus.w_addr_glb_psum   = glb_addr;
                bus.w_data_glb_psum   = psum_reg;
            end
            DONE:    bus.psum_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_router_psum_wb.sv
// tb/tb_router_psum_wb.sv - scoreboard bench for router_psum_wb with spad/GLB memory models
`timescale 1ns/1ps
module tb_router_psum_wb;
    localparam int DW        = 16;
    localparam int AG        = 10;
    localparam int AS        = 9;
    localparam int OUT_SIZE  = 3;
    localparam int N         = OUT_SIZE * OUT_SIZE;
    localparam int SPAD_BASE = 0;
    localparam int GLB_BASE  = 500;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    router_psum_wb_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AG), .ADDR_BITWIDTH_SPAD(AS)) bus();

    router_psum_wb #(
        .DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AG), .ADDR_BITWIDTH_SPAD(AS),
        .OUT_SIZE(OUT_SIZE), .PSUM_SPAD_ADDR(SPAD_BASE), .PSUM_GLB_ADDR(GLB_BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] spad_mem [0:(1<<AS)-1];
    logic [DW-1:0] glb_mem  [0:(1<<AG)-1];
    logic [DW-1:0] glb_ref  [0:(1<<AG)-1];

    typedef struct {
        int addr;
        int data;
        int when;
    } wr_t;
    wr_t wr_q[$];
    int  done_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Memories: a read strobe seen in a cycle makes data available from then on.
    always @(negedge clk) begin
        if (bus.read_req_spad_psum) bus.r_data_spad_psum = spad_mem[bus.r_addr_spad_psum];
        if (bus.read_req_glb_psum)  bus.r_data_glb_psum  = glb_mem[bus.r_addr_glb_psum];
        if (bus.write_en_glb_psum)  glb_mem[bus.w_addr_glb_psum] = bus.w_data_glb_psum;
    end

    // Monitor: every write and completion pulse must match the head of its queue.
    always @(negedge clk) begin
        if (bus.write_en_glb_psum) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("write_addr", 32'(bus.w_addr_glb_psum), e.addr);
                check("write_data", 32'(bus.w_data_glb_psum), e.data);
                check("write_cycle", cyc, e.when);
            end
        end
        if (bus.psum_done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                int t;
                t = done_q.pop_front();
                check("done_cycle", cyc, t);
            end
        end
    end

    // Reference model: the element sequence of one transaction started in cycle t0.
    task automatic expect_txn(input bit acc, input int t0, input int n_el);
        int per;
        per = acc ? 5 : 3;
        for (int i = 0; i < n_el; i++) begin
            int sa;
            int ga;
            int d;
            wr_t e;
            sa = (SPAD_BASE + i) % (1 << AS);
            ga = (GLB_BASE + i) % (1 << AG);
            if (acc) d = (int'(spad_mem[sa]) + int'(glb_ref[ga])) % (1 << DW);
            else     d = int'(spad_mem[sa]);
            glb_ref[ga] = DW'(d);
            e.addr = ga;
            e.data = d;
            e.when = t0 + per * (i + 1);
            wr_q.push_back(e);
        end
        if (n_el == N) done_q.push_back(t0 + per * N + 1);
    endtask

    task automatic fill_spad_random();
        for (int i = 0; i < N; i++) spad_mem[(SPAD_BASE + i) % (1 << AS)] = DW'($urandom);
    endtask

    function automatic logic [31:0] outputs_or();
        return 32'(bus.r_addr_spad_psum) | 32'(bus.read_req_spad_psum) | 32'(bus.r_addr_glb_psum)
             | 32'(bus.read_req_glb_psum) | 32'(bus.w_data_glb_psum) | 32'(bus.w_addr_glb_psum)
             | 32'(bus.write_en_glb_psum) | 32'(bus.busy) | 32'(bus.psum_done);
    endfunction

    // Issue a one-cycle start; returns at the negedge of cycle 1 with t0 = start cycle.
    task automatic start(input bit acc, input int n_el, output int t0);
        @(negedge clk);
        bus.write_psum_ctrl = 1'b1;
        bus.accumulate      = acc;
        t0 = cyc;
        expect_txn(acc, t0, n_el);
        @(negedge clk);
        bus.write_psum_ctrl = 1'b0;
        bus.accumulate      = 1'($urandom);
        check("busy_after_start", 32'(bus.busy), 1);
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = 0;
        while ((wr_q.size() != 0 || done_q.size() != 0) && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            check("timeout_pending", wr_q.size() + done_q.size(), 0);
            wr_q.delete();
            done_q.delete();
        end
        @(negedge clk);
        check("idle_after_done", 32'(bus.busy), 0);
    endtask

    initial begin
        int t0;
        int per;
        bit acc;

        bus.write_psum_ctrl  = 1'b0;
        bus.accumulate       = 1'b0;
        bus.r_data_spad_psum = '0;
        bus.r_data_glb_psum  = '0;
        for (int a = 0; a < (1 << AS); a++) spad_mem[a] = '0;
        for (int a = 0; a < (1 << AG); a++) begin
            glb_mem[a] = DW'($urandom);
            glb_ref[a] = glb_mem[a];
        end

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", outputs_or(), 0);
        reset = 1'b0;

        // Overwrite of 1..9
        for (int i = 0; i < N; i++) spad_mem[SPAD_BASE + i] = DW'(i + 1);
        start(1'b0, N, t0);
        wait_idle(200);
        check("overwrite_glb_508", 32'(glb_mem[GLB_BASE + 8]), 9);

        // Accumulate onto 100
        for (int i = 0; i < N; i++) begin
            glb_mem[GLB_BASE + i] = DW'(100);
            glb_ref[GLB_BASE + i] = DW'(100);
        end
        start(1'b1, N, t0);
        wait_idle(200);
        check("accumulate_glb_500", 32'(glb_mem[GLB_BASE]), 101);

        // Wraparound of the 16-bit sum
        spad_mem[SPAD_BASE] = 16'hFFFF;
        glb_mem[GLB_BASE]   = 16'h0002;
        glb_ref[GLB_BASE]   = 16'h0002;
        start(1'b1, N, t0);
        wait_idle(200);
        check("wrap_glb_500", 32'(glb_mem[GLB_BASE]), 1);

        // Start and mode toggling while busy are ignored
        for (int k = 0; k < 2; k++) begin
            acc = 1'(k);
            per = acc ? 5 : 3;
            fill_spad_random();
            start(acc, N, t0);
            while (cyc < t0 + per * N) begin
                bus.write_psum_ctrl = 1'($urandom);
                bus.accumulate      = 1'($urandom);
                @(negedge clk);
            end
            bus.write_psum_ctrl = 1'b0;
            wait_idle(200);
        end

        // Reset in the cycle after the 4th write aborts the transaction
        for (int k = 0; k < 2; k++) begin
            acc = 1'(k);
            per = acc ? 5 : 3;
            fill_spad_random();
            start(acc, 4, t0);
            while (cyc < t0 + per * 4 + 1) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("abort_outputs", outputs_or(), 0);
            reset = 1'b0;
            repeat (60) @(negedge clk);
            check("abort_quiet_busy", 32'(bus.busy), 0);
            check("abort_pending", wr_q.size() + done_q.size(), 0);
            fill_spad_random();
            start(1'b0, N, t0);
            wait_idle(200);
        end

        // Start held high: back-to-back accumulate transactions
        fill_spad_random();
        @(negedge clk);
        bus.write_psum_ctrl = 1'b1;
        bus.accumulate      = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 3; k++) expect_txn(1'b1, t0 + k * (5 * N + 2), N);
        while (cyc < t0 + 2 * (5 * N + 2) + 1) begin
            @(negedge clk);
            if (cyc == t0 + 5 * N + 2) check("b2b_idle_gap", 32'(bus.busy), 0);
            if (cyc == t0 + 5 * N + 3) check("b2b_restart", 32'(bus.busy), 1);
        end
        bus.write_psum_ctrl = 1'b0;
        wait_idle(400);

        // Random transactions
        for (int k = 0; k < 6; k++) begin
            acc = 1'($urandom);
            fill_spad_random();
            start(acc, N, t0);
            wait_idle(200);
        end

        check("final_pending", wr_q.size() + done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
